mc_array_ctrl: RTL and testbench
================================

// Module: mc_array_ctrl
// PURPOSE
//  Sequencer directly upstream of the 8x8 memristor array macro. Accepts row-wide program/read requests over
//  valid/ready, drives the array row/column lines (CWLE/CWLO, CBLEN, CBL, CSL, DIN, DINb) with correct phase
//  ordering, and returns read data decoded from the array DOUT bus. Only block allowed to touch the array pins.
// PARAMETERS
//  PROG_CYCLES  4  cycles each programming phase (A, B) is held; legal >= 1
//  MAX_RETRY    2  extra program attempts after failed verify (used only with MC_CTRL_VERIFY_EN)
// PORTS
//  clk_i        in   1  clock; all state updates on rising edge
//  rst_i        in   1  synchronous, active-high reset
//  req_valid_i  in   1  request valid
//  req_ready_o  out  1  request accept; transfer when valid & ready
//  req_write_i  in   1  1 = program row, 0 = read row
//  req_row_i    in   3  row index 0..7
//  req_wdata_i  in   8  data bit per column (1 => m0=1,m1=0; 0 => m0=0,m1=1)
//  req_wmask_i  in   8  per-column program enable (drives CBLEN)
//  rsp_valid_o  out  1  one-cycle response pulse, no backpressure
//  rsp_rdata_o  out  8  read data (valid with rsp_valid_o)
//  rsp_err_o    out  1  verify failure (0 unless MC_CTRL_VERIFY_EN)
//  mc_cwle_o / mc_cwlo_o  out 4  row select; row r -> CWLE[r>>1] if r odd, CWLO[r>>1] if r even; one-hot or zero
//  mc_cblen_o, mc_cbl_o, mc_csl_o, mc_din_o, mc_dinb_o  out 8  column lines, all registered
//  mc_dout_i    in   8  array DOUT
// BEHAVIOUR
//  - Reset: state IDLE, every output 0 except req_ready_o=1; counters and rdata cleared. Reset mid-operation
//    aborts: no response issued, array lines 0 from the next edge.
//  - IDLE: all array lines 0, ready=1. On valid&ready latch row/write/wdata/wmask; ready=0 until back in IDLE.
//  - PROG_A (PROG_CYCLES): row line=1, CBLEN=wmask, CBL=~wdata, CSL=wdata  (cmd 01 -> m0=1 / 10 -> m0=0).
//  - GAP (1 cycle): all array lines 0 (no command overlap when CBL/CSL change).
//  - PROG_B (PROG_CYCLES): row line=1, CBLEN=wmask, CBL=~wdata, CSL=~wdata (cmd 00 -> m1=0 / 11 -> m1=1).
//  - RD_ARM (1): row line=1, CBLEN=0, CSL=8'hFF, DIN=DINb=0 (arms cell read enable).
//  - RD_EVAL (1): row line=1, CBLEN=0, CSL=0, DIN=8'hFF, DINb=0; at end of cycle rdata <= ~mc_dout_i.
//  - RESP (1): array lines 0, rsp_valid_o=1 -> IDLE next cycle. rsp_rdata_o holds last captured value
//    (0 for writes without verify).
//  - Latency accept->rsp_valid: read 3 cycles; write 2*PROG_CYCLES+2 (no verify).
//  - Counter width $clog2(PROG_CYCLES+1); reloads on every phase entry.
//  - wmask=0 write still runs full sequence (no cell changes). Back-to-back requests: earliest next accept is
//    the IDLE cycle after RESP. req_* ignored while ready=0.
// CONFIGURATION
//  MC_CTRL_VERIFY_EN defined: after PROG_B -> GAP -> RD_ARM -> RD_EVAL -> VERIFY. VERIFY compares
//   (rdata ^ wdata) & wmask; zero -> RESP err=0; nonzero and tries < MAX_RETRY -> GAP -> PROG_A, tries++;
//   else RESP err=1. Write responses carry the readback in rsp_rdata_o.
//  Undefined: VERIFY state and retry counter absent, rsp_err_o tied 0.
// STRUCTURE
//  mc_ctrl_pkg: state enum (IDLE,PROG_A,GAP,PROG_B,RD_ARM,RD_EVAL,VERIFY,RESP), program command constants
//   (CMD_M1_CLR=2'b00, CMD_M0_SET=2'b01, CMD_M0_CLR=2'b10, CMD_M1_SET=2'b11), row->CWLE/CWLO function.
//  Sub-module mc_row_decoder: row + enable -> registered mc_cwle_o/mc_cwlo_o.
// TESTING (bench uses the behavioural array model as DUT load)
//  1 reset mid PROG_B with PROG_CYCLES=4 -> next cycle all array lines 0, ready=1, no rsp_valid.
//  2 write row 5 wdata=8'hA5 wmask=8'hFF, then read row 5 -> read rsp after 3 cycles, rdata=8'hA5;
//    CWLE=4'b0100 while active.
//  3 write row 0 8'hFF, then write row 0 wdata=8'h00 wmask=8'h0F; read -> 8'hF0.
//  4 write row 2 8'h3C, write row 3 8'hC3; read rows 2,3 -> 8'h3C, 8'hC3 (no row crosstalk, CWLO[1] vs CWLE[1]).
//  5 write latency check PROG_CYCLES=1 -> rsp_valid exactly 4 cycles after accept; ready low throughout.
//  6 VERIFY_EN, model forced stuck-at on column 0, write 8'h01 -> MAX_RETRY+1 PROG_A entries, rsp_err_o=1,
//    rsp_rdata_o[0]=0; clean write -> err=0 on first try.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and helpers for the memristor array controller.
// States, program command encodings and the row to word-line mapping.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE, PROG_A, GAP, PROG_B, RD_ARM, RD_EVAL, VERIFY, RESP
    } state_t;

    // {CBL, CSL} commands seen by a selected, enabled cell
    localparam logic [1:0] CMD_M1_CLR = 2'b00;
    localparam logic [1:0] CMD_M0_SET = 2'b01;
    localparam logic [1:0] CMD_M0_CLR = 2'b10;
    localparam logic [1:0] CMD_M1_SET = 2'b11;

    // Returns {cwle, cwlo}: odd rows live on CWLE, even rows on CWLO
    function automatic logic [7:0] row_lines(input logic [2:0] row);
        logic [7:0] v;
        v = '0;
        v[{row[0], row[2:1]}] = 1'b1;
        return v;
    endfunction

    function automatic logic [1:0] prog_cmd(input logic phase_b, input logic bit_v);
        if (phase_b) return bit_v ? CMD_M1_CLR : CMD_M1_SET;
        return bit_v ? CMD_M0_SET : CMD_M0_CLR;
    endfunction

endpackage

// File: rtl/mc_row_decoder.sv
// Registered row decoder driving the array CWLE/CWLO word lines.
// Output is one-hot for the selected row, or all zero when disabled.
module mc_row_decoder
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] row,
    output logic [3:0] cwle,
    output logic [3:0] cwlo
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cwle <= '0;
            cwlo <= '0;
        end else begin
            {cwle, cwlo} <= en ? row_lines(row) : 8'h00;
        end
    end

endmodule

// File: rtl/mc_array_ctrl.sv
// Program/read sequencer for the 8x8 memristor array macro.
// Define MC_CTRL_VERIFY_EN to add post-program verify with retry.
module mc_array_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int PROG_CYCLES = 4,
    parameter int MAX_RETRY   = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_write_i,
    input  logic [2:0] req_row_i,
    input  logic [7:0] req_wdata_i,
    input  logic [7:0] req_wmask_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_err_o,
    output logic [3:0] mc_cwle_o,
    output logic [3:0] mc_cwlo_o,
    output logic [7:0] mc_cblen_o,
    output logic [7:0] mc_cbl_o,
    output logic [7:0] mc_csl_o,
    output logic [7:0] mc_din_o,
    output logic [7:0] mc_dinb_o,
    input  logic [7:0] mc_dout_i
);

    localparam int CW = $clog2(PROG_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PROG_CYCLES - 1);

    state_t        state, state_n, gap_tgt, gap_tgt_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    row, row_d;
    logic [7:0]    wdata, wdata_d, wmask, wmask_d, rdata;
    logic          accept, row_en;
    logic [7:0]    cblen_d, cbl_d, csl_d, din_d;
    logic [1:0]    cmd;

    if (PROG_CYCLES < 1 || MAX_RETRY < 0) begin : g_bad_cfg
    end

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign row_d       = accept ? req_row_i   : row;
    assign wdata_d     = accept ? req_wdata_i : wdata;
    assign wmask_d     = accept ? req_wmask_i : wmask;
    assign rsp_rdata_o = rdata;

`ifdef MC_CTRL_VERIFY_EN
    localparam int TW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [TW-1:0] tries, tries_n;
    logic          wr, err, err_n, miss;

    assign miss      = |((rdata ^ wdata) & wmask);
    assign rsp_err_o = err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tries <= '0;
            err   <= 1'b0;
            wr    <= 1'b0;
        end else begin
            tries <= tries_n;
            err   <= err_n;
            if (accept) wr <= req_write_i;
        end
    end
`else
    assign rsp_err_o = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        gap_tgt_n = gap_tgt;
        cnt_n     = cnt;
`ifdef MC_CTRL_VERIFY_EN
        tries_n   = tries;
        err_n     = err;
`endif
        unique case (state)
            IDLE: if (accept) begin
                state_n = req_write_i ? PROG_A : RD_ARM;
                cnt_n   = CNT_LOAD;
`ifdef MC_CTRL_VERIFY_EN
                tries_n = '0;
                err_n   = 1'b0;
`endif
            end
            PROG_A: if (cnt == '0) begin
                state_n   = GAP;
                gap_tgt_n = PROG_B;
            end else begin
                cnt_n = cnt - 1'b1;
            end
            GAP: begin
                state_n = gap_tgt;
                cnt_n   = CNT_LOAD;
            end
            PROG_B: if (cnt == '0) begin
`ifdef MC_CTRL_VERIFY_EN
                state_n   = GAP;
                gap_tgt_n = RD_ARM;
`else
                state_n   = RESP;
`endif
            end else begin
                cnt_n = cnt - 1'b1;
            end
            RD_ARM:  state_n = RD_EVAL;
`ifdef MC_CTRL_VERIFY_EN
            RD_EVAL: state_n = wr ? VERIFY : RESP;
            VERIFY: if (!miss) begin
                state_n = RESP;
            end else if (int'(tries) < MAX_RETRY) begin
                state_n   = GAP;
                gap_tgt_n = PROG_A;
                tries_n   = tries + 1'b1;
            end else begin
                state_n = RESP;
                err_n   = 1'b1;
            end
`else
            RD_EVAL: state_n = RESP;
            VERIFY:  state_n = IDLE;
`endif
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Array lines are decoded from the next state so they register in step with it
    always_comb begin
        row_en  = 1'b0;
        cblen_d = '0;
        cbl_d   = '0;
        csl_d   = '0;
        din_d   = '0;
        cmd     = '0;
        unique case (state_n)
            PROG_A, PROG_B: begin
                row_en  = 1'b1;
                cblen_d = wmask_d;
                for (int c = 0; c < 8; c++) begin
                    cmd      = prog_cmd(state_n == PROG_B, wdata_d[c]);
                    cbl_d[c] = cmd[1];
                    csl_d[c] = cmd[0];
                end
            end
            RD_ARM: begin
                row_en = 1'b1;
                csl_d  = 8'hFF;
            end
            RD_EVAL: begin
                row_en = 1'b1;
                din_d  = 8'hFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            gap_tgt     <= PROG_B;
            cnt         <= '0;
            row         <= '0;
            wdata       <= '0;
            wmask       <= '0;
            rdata       <= '0;
            rsp_valid_o <= 1'b0;
            mc_cblen_o  <= '0;
            mc_cbl_o    <= '0;
            mc_csl_o    <= '0;
            mc_din_o    <= '0;
            mc_dinb_o   <= '0;
        end else begin
            state       <= state_n;
            gap_tgt     <= gap_tgt_n;
            cnt         <= cnt_n;
            row         <= row_d;
            wdata       <= wdata_d;
            wmask       <= wmask_d;
            rsp_valid_o <= (state_n == RESP);
            mc_cblen_o  <= cblen_d;
            mc_cbl_o    <= cbl_d;
            mc_csl_o    <= csl_d;
            mc_din_o    <= din_d;
            mc_dinb_o   <= '0;
            if (accept) begin
                rdata <= '0;
            end else if (state == RD_EVAL) begin
                rdata <= ~mc_dout_i;
            end
        end
    end

    mc_row_decoder u_row_dec (
        .clk  (clk_i),
        .rst  (rst_i),
        .en   (row_en),
        .row  (row_d),
        .cwle (mc_cwle_o),
        .cwlo (mc_cwlo_o)
    );

endmodule

// File: tb/tb_mc_array_ctrl.sv
// Bench for mc_array_ctrl with a behavioural 8x8 memristor array as load.
// Build with MC_CTRL_VERIFY_EN defined to exercise verify/retry.
module tb_mc_array_ctrl;

    localparam int P    = 4;
    localparam int MAXR = 2;

    logic       clk, rst;
    logic       req_valid, req_ready, req_write;
    logic [2:0] req_row;
    logic [7:0] req_wdata, req_wmask;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic [3:0] cwle, cwlo;
    logic [7:0] cblen, cbl, csl, din, dinb, dout;

    logic       f_valid, f_ready, f_rsp_valid, f_err;
    logic [7:0] f_rdata, f_cblen, f_cbl, f_csl, f_din, f_dinb;
    logic [3:0] f_cwle, f_cwlo;
    logic [7:0] f_dout;

    int checks = 0;
    int failures = 0;

    logic [7:0] m0 [8] = '{default: 8'h00};
    logic [7:0] m1 [8] = '{default: 8'hFF};
    logic [7:0] ref_mem [8] = '{default: 8'h00};
    bit stuck = 0;

    mc_array_ctrl #(.PROG_CYCLES(P), .MAX_RETRY(MAXR)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_row_i(req_row),
        .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mc_cwle_o(cwle), .mc_cwlo_o(cwlo), .mc_cblen_o(cblen),
        .mc_cbl_o(cbl), .mc_csl_o(csl), .mc_din_o(din), .mc_dinb_o(dinb),
        .mc_dout_i(dout)
    );

    mc_array_ctrl #(.PROG_CYCLES(1), .MAX_RETRY(MAXR)) dut_fast (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(f_valid), .req_ready_o(f_ready),
        .req_write_i(req_write), .req_row_i(req_row),
        .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .rsp_valid_o(f_rsp_valid), .rsp_rdata_o(f_rdata), .rsp_err_o(f_err),
        .mc_cwle_o(f_cwle), .mc_cwlo_o(f_cwlo), .mc_cblen_o(f_cblen),
        .mc_cbl_o(f_cbl), .mc_csl_o(f_csl), .mc_din_o(f_din), .mc_dinb_o(f_dinb),
        .mc_dout_i(f_dout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic bit row_on(input logic [3:0] le, input logic [3:0] lo, input int r);
        return r[0] ? le[r>>1] : lo[r>>1];
    endfunction

    // Array model: a selected, enabled cell applies the {CBL,CSL} command at the clock edge
    always @(posedge clk) begin
        for (int r = 0; r < 8; r++) begin
            if (row_on(cwle, cwlo, r)) begin
                for (int c = 0; c < 8; c++) begin
                    if (cblen[c]) begin
                        case ({cbl[c], csl[c]})
                            2'b01: m0[r][c] <= 1'b1;
                            2'b10: m0[r][c] <= 1'b0;
                            2'b00: m1[r][c] <= 1'b0;
                            default: m1[r][c] <= 1'b1;
                        endcase
                    end
                end
            end
        end
    end

    // DOUT is active-low cell state while DIN is driven
    always_comb begin
        dout = 8'hFF;
        for (int r = 0; r < 8; r++) begin
            if (row_on(cwle, cwlo, r)) begin
                for (int c = 0; c < 8; c++) begin
                    if (din[c]) dout[c] = ~(m0[r][c] & ~(stuck && c == 0));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input bit w);
`ifdef MC_CTRL_VERIFY_EN
        return w ? 2*P + 6 : 3;
`else
        return w ? 2*P + 2 : 3;
`endif
    endfunction

    function automatic logic [7:0] exp_wr_rdata(input logic [2:0] r);
`ifdef MC_CTRL_VERIFY_EN
        return ref_mem[r];
`else
        return (r == 3'd0) ? 8'h00 : 8'h00;
`endif
    endfunction

    task automatic do_op(input bit w, input logic [2:0] r, input logic [7:0] d,
                         input logic [7:0] m, output logic [7:0] rd, output logic er,
                         output int lat, output bit ok, output logic [3:0] le,
                         output logic [3:0] lo, output int pa_n);
        int n;
        bit pa, pa_prev;
        ok = 1; le = '0; lo = '0; pa_n = 0; pa_prev = 0; n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        req_valid = 1; req_write = w; req_row = r; req_wdata = d; req_wmask = m;
        if (w) ref_mem[r] = (ref_mem[r] & ~m) | (d & m);
        tick();
        lat = 1;
        // Keep valid high with junk while busy: it must be ignored
        req_write = 1'($urandom); req_row = 3'($urandom);
        req_wdata = 8'($urandom); req_wmask = 8'($urandom);
        while (!rsp_valid && lat < 200) begin
            if (req_ready || dinb != 0) ok = 0;
            le |= cwle;
            lo |= cwlo;
            pa = ((cwle | cwlo) != 0) && (cblen != 0) && (csl == ~cbl);
            if (pa && !pa_prev) pa_n++;
            pa_prev = pa;
            tick();
            lat++;
        end
        req_valid = 0;
        rd = rsp_rdata;
        er = rsp_err;
        if (req_ready || {cwle, cwlo, cblen, cbl, csl, din, dinb} != 0) ok = 0;
        tick();
        if (rsp_valid || !req_ready) ok = 0;
    endtask

    task automatic test_reset();
        rst = 1; req_valid = 0; f_valid = 0; req_write = 0;
        req_row = 0; req_wdata = 0; req_wmask = 0; f_dout = 8'hFF;
        repeat (3) tick();
        checks++;
        if ({cwle, cwlo, cblen, cbl, csl, din, dinb, rsp_valid, rsp_rdata, rsp_err} !== 0
            || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state ready=%b valid=%b rdata=%h lines=%h/%h/%h/%h/%h",
                     req_ready, rsp_valid, rsp_rdata, cwle, cwlo, cblen, cbl, csl);
        end
        rst = 0;
        tick();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset ready=%b valid=%b exp 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_abort();
        bit quiet;
        logic [7:0] rd; logic er; int lat; bit ok; logic [3:0] le, lo; int pa_n;
        req_valid = 1; req_write = 1; req_row = 3'd1; req_wdata = 8'h96; req_wmask = 8'hFF;
        tick();
        req_valid = 0;
        repeat (6) tick();
        checks++;
        if (cwlo !== 4'b0000 || cwle !== 4'b0001 || csl !== cbl || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_prog_b cwle=%b cwlo=%b csl=%h cbl=%h ready=%b",
                     cwle, cwlo, csl, cbl, req_ready);
        end
        rst = 1;
        tick();
        checks++;
        if ({cwle, cwlo, cblen, cbl, csl, din, dinb} !== 0 || req_ready !== 1'b1
            || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset lines=%h/%h/%h ready=%b valid=%b exp 0/1/0",
                     cwle, cwlo, cblen, req_ready, rsp_valid);
        end
        rst = 0;
        quiet = 1;
        repeat (12) begin
            tick();
            if (rsp_valid) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL abort_no_rsp got rsp_valid after abort");
        end
        // Phase A had finished, so the row already reads back the new data
        ref_mem[1] = 8'h96;
        do_op(0, 3'd1, 8'h00, 8'h00, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (rd !== ref_mem[1]) begin
            failures++;
            $display("FAIL abort_readback got=%h exp=%h", rd, ref_mem[1]);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] rd; logic er; int lat; bit ok; logic [3:0] le, lo; int pa_n;
        do_op(1, 3'd5, 8'hA5, 8'hFF, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (lat !== exp_lat(1) || !ok || le !== 4'b0100 || lo !== 4'b0000) begin
            failures++;
            $display("FAIL wr_row5 lat=%0d exp=%0d ok=%b cwle=%b cwlo=%b exp 0100/0000",
                     lat, exp_lat(1), ok, le, lo);
        end
        checks++;
        if (m1[5] !== 8'h5A) begin
            failures++;
            $display("FAIL wr_row5_m1 got=%h exp=5a", m1[5]);
        end
        do_op(0, 3'd5, 8'h00, 8'h00, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (lat !== 3 || rd !== 8'hA5 || !ok || le !== 4'b0100) begin
            failures++;
            $display("FAIL rd_row5 lat=%0d rdata=%h ok=%b cwle=%b exp 3/a5/1/0100",
                     lat, rd, ok, le);
        end
    endtask

    task automatic test_mask();
        logic [7:0] rd; logic er; int lat; bit ok; logic [3:0] le, lo; int pa_n;
        do_op(1, 3'd0, 8'hFF, 8'hFF, rd, er, lat, ok, le, lo, pa_n);
        do_op(1, 3'd0, 8'h00, 8'h0F, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (rd !== exp_wr_rdata(3'd0) || er !== 1'b0) begin
            failures++;
            $display("FAIL mask_wr_rsp rdata=%h err=%b exp %h/0", rd, er, exp_wr_rdata(3'd0));
        end
        do_op(0, 3'd0, 8'h00, 8'h00, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (rd !== 8'hF0 || lo !== 4'b0001 || le !== 4'b0000) begin
            failures++;
            $display("FAIL mask_rd got=%h cwlo=%b exp f0/0001", rd, lo);
        end
    endtask

    task automatic test_rows();
        logic [7:0] rd; logic er; int lat; bit ok; logic [3:0] le, lo; int pa_n;
        do_op(1, 3'd2, 8'h3C, 8'hFF, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (lo !== 4'b0010 || le !== 4'b0000) begin
            failures++;
            $display("FAIL row2_lines cwle=%b cwlo=%b exp 0000/0010", le, lo);
        end
        do_op(1, 3'd3, 8'hC3, 8'hFF, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (le !== 4'b0010 || lo !== 4'b0000) begin
            failures++;
            $display("FAIL row3_lines cwle=%b cwlo=%b exp 0010/0000", le, lo);
        end
        do_op(0, 3'd2, 8'h00, 8'h00, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (rd !== 8'h3C) begin
            failures++;
            $display("FAIL rd_row2 got=%h exp=3c", rd);
        end
        do_op(0, 3'd3, 8'h00, 8'h00, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (rd !== 8'hC3) begin
            failures++;
            $display("FAIL rd_row3 got=%h exp=c3", rd);
        end
    endtask

    task automatic test_latency();
        int lat, exp;
        bit low;
`ifdef MC_CTRL_VERIFY_EN
        exp = 2*1 + 6;
`else
        exp = 2*1 + 2;
`endif
        low = 1;
        req_write = 1; req_row = 3'd4; req_wdata = 8'($urandom); req_wmask = 8'h00;
        f_valid = 1;
        tick();
        f_valid = 0;
        lat = 1;
        while (!f_rsp_valid && lat < 50) begin
            if (f_ready) low = 0;
            tick();
            lat++;
        end
        if (f_ready) low = 0;
        checks++;
        if (lat !== exp || !low) begin
            failures++;
            $display("FAIL fast_wr_latency lat=%0d exp=%0d ready_low=%b", lat, exp, low);
        end
        checks++;
        if (f_rdata !== 8'h00 || f_err !== 1'b0
            || {f_cwle, f_cwlo, f_cblen, f_cbl, f_csl, f_din, f_dinb} !== 0) begin
            failures++;
            $display("FAIL fast_wr_rsp rdata=%h err=%b lines=%h/%h exp 00/0/0",
                     f_rdata, f_err, f_cwle, f_cwlo);
        end
        tick();
        checks++;
        if (f_ready !== 1'b1 || f_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL fast_idle ready=%b valid=%b exp 1/0", f_ready, f_rsp_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, d, m, exp_rd; logic er; int lat; bit ok, w;
        logic [3:0] le, lo; int pa_n;
        logic [2:0] r;
        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom);
            r = 3'($urandom);
            d = 8'($urandom);
            case ($urandom_range(0, 3))
                0: m = 8'h00;
                1: m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            do_op(w, r, d, m, rd, er, lat, ok, le, lo, pa_n);
            exp_rd = w ? exp_wr_rdata(r) : ref_mem[r];
            checks++;
            if (rd !== exp_rd || lat !== exp_lat(w) || !ok || er !== 1'b0) begin
                failures++;
                $display("FAIL rand_op%0d w=%b row=%0d rdata=%h exp=%h lat=%0d exp=%0d ok=%b err=%b",
                         i, w, r, rd, exp_rd, lat, exp_lat(w), ok, er);
            end
        end
    endtask

`ifdef MC_CTRL_VERIFY_EN
    task automatic test_verify();
        logic [7:0] rd; logic er; int lat; bit ok; logic [3:0] le, lo; int pa_n;
        stuck = 1;
        do_op(1, 3'd6, 8'h01, 8'hFF, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (pa_n !== MAXR + 1 || er !== 1'b1 || rd !== 8'h00
            || lat !== 2*P + 5 + MAXR*(2*P + 6) + 1) begin
            failures++;
            $display("FAIL verify_stuck prog_a=%0d err=%b rdata=%h lat=%0d exp %0d/1/00/%0d",
                     pa_n, er, rd, lat, MAXR + 1, 2*P + 5 + MAXR*(2*P + 6) + 1);
        end
        stuck = 0;
        do_op(1, 3'd6, 8'h5A, 8'hFF, rd, er, lat, ok, le, lo, pa_n);
        checks++;
        if (pa_n !== 1 || er !== 1'b0 || rd !== 8'h5A || lat !== 2*P + 6) begin
            failures++;
            $display("FAIL verify_clean prog_a=%0d err=%b rdata=%h lat=%0d exp 1/0/5a/%0d",
                     pa_n, er, rd, lat, 2*P + 6);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_abort();
        test_write_read();
        test_mask();
        test_rows();
        test_latency();
        test_random();
`ifdef MC_CTRL_VERIFY_EN
        test_verify();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
